// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt latch front-end: widths, FSM encoding
// and the index-to-one-hot helper used when retiring a served request.
package irq_pkg;

  localparam int unsigned N   = 8;
  localparam int unsigned IDW = 3;

  typedef enum logic {
    StIdle   = 1'b0,
    StAssert = 1'b1
  } state_e;

  function automatic logic [N-1:0] idx_onehot(input logic [IDW-1:0] idx);
    return N'(1) << idx;
  endfunction

endpackage

// File: rtl/pe.sv
// 8-to-3 priority encoder: the highest set input bit wins; all-zero input yields 0.
module pe (
  input  logic [7:0] in,
  output logic [2:0] out
);

  always_comb begin
    out = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (in[i]) out = 3'(i);
    end
  end

endmodule

// File: rtl/irq_latch_ctrl.sv
// Interrupt front-end: edge-detects request lines into sticky pending bits, arbitrates
// the unmasked ones through `pe` and holds the winner on a valid/ack handshake.
module irq_latch_ctrl
  import irq_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   irq_in,
  input  logic [N-1:0]   irq_mask,
  input  logic           irq_ack,
  input  logic           ovr_clr,
  output logic           irq_valid,
  output logic [IDW-1:0] irq_id,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   overrun
);

  logic [N-1:0]   r_irq_prev;
  logic [N-1:0]   r_pending;
  logic [N-1:0]   r_overrun;
  state_e         r_state;
  logic           r_valid;
  logic [IDW-1:0] r_id;

  logic [N-1:0]   w_rise;
  logic           w_ack;
  logic [N-1:0]   w_clr;
  logic [N-1:0]   w_pending_d;
  logic [N-1:0]   w_ovr_set;
  logic [N-1:0]   w_overrun_d;
  logic [N-1:0]   w_masked;
  logic [IDW-1:0] w_pe_out;
  state_e         w_state_d;
  logic           w_valid_d;
  logic [IDW-1:0] w_id_d;

  pe u_pe (
    .in  (w_masked),
    .out (w_pe_out)
  );

  // A rise on the bit being retired this cycle re-arms it rather than counting as overrun.
  always_comb begin
    w_rise      = irq_in & ~r_irq_prev;
    w_ack       = (r_state == StAssert) & irq_ack;
    w_clr       = w_ack ? idx_onehot(r_id) : '0;
    w_pending_d = (r_pending & ~w_clr) | w_rise;
    w_ovr_set   = w_rise & r_pending & ~w_clr;
    w_overrun_d = (ovr_clr ? '0 : r_overrun) | w_ovr_set;
    w_masked    = r_pending & ~irq_mask;
  end

  always_comb begin
    w_state_d = r_state;
    w_valid_d = r_valid;
    w_id_d    = r_id;
    unique case (r_state)
      StIdle: begin
        if (w_masked != '0) begin
          w_state_d = StAssert;
          w_valid_d = 1'b1;
          w_id_d    = w_pe_out;
        end
      end
      StAssert: begin
        if (irq_ack) begin
          w_state_d = StIdle;
          w_valid_d = 1'b0;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_prev <= '0;
      r_pending  <= '0;
      r_overrun  <= '0;
      r_state    <= StIdle;
      r_valid    <= 1'b0;
      r_id       <= '0;
    end else begin
      r_irq_prev <= irq_in;
      r_pending  <= w_pending_d;
      r_overrun  <= w_overrun_d;
      r_state    <= w_state_d;
      r_valid    <= w_valid_d;
      r_id       <= w_id_d;
    end
  end

  assign irq_valid = r_valid;
  assign irq_id    = r_id;
  assign pending   = r_pending;
  assign overrun   = r_overrun;

endmodule
